// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
// Slot rd fields are stored at SLOT_RD_W bits, so REG_AW up to 8 is supported.
package hazard_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned SLOT_RD_W      = 8;
    localparam int unsigned FWD_SEL_RF     = 0;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 is_load;
    } slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Priority compare of one EX source register against the N forwarding slots;
// the nearest (lowest-numbered) matching slot wins.
module fwd_select
    import hazard_pkg::*;
#(
    parameter  int unsigned NUM_FWD_STAGES = 2,
    parameter  int unsigned RD_W           = SLOT_RD_W,
    localparam int unsigned SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                             en,
    input  logic [RD_W-1:0]                  src,
    input  logic [NUM_FWD_STAGES-1:0]        cand_valid,
    input  logic [NUM_FWD_STAGES*RD_W-1:0]   cand_rd,
    output logic [SEL_W-1:0]                 sel
);

    logic found;

    always_comb begin
        sel   = SEL_W'(FWD_SEL_RF);
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_FWD_STAGES; k++) begin
            if (!found && en && cand_valid[k] && (cand_rd[k*RD_W +: RD_W] == src)) begin
                sel   = SEL_W'(k + 1);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadow slots EX..S[N], bypass selects,
// load-use stall and the optional mul/div EX hold (enabled by HAZ_MULDIV_EN).
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int unsigned NUM_FWD_STAGES = 2,
    parameter  int unsigned REG_AW         = REG_AW_DEFAULT,
    parameter  int unsigned MD_LAT         = 4,
    localparam int unsigned FWD_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic              MulDiv_ID,
    input  logic              flush,
    output logic [FWD_W-1:0]  ForwardA,
    output logic [FWD_W-1:0]  ForwardB,
    output logic              stall,
    output logic              ex_busy
);

    slot_t                              ex_slot;
    slot_t                              ex_nxt;
    slot_t                              id_slot;
    logic [SLOT_RD_W-1:0]               ex_rs1, ex_rs2;
    logic [SLOT_RD_W-1:0]               ex_rs1_nxt, ex_rs2_nxt;
    slot_t [NUM_FWD_STAGES:1]           fwd_slot;
    logic                               load_use;
    logic [NUM_FWD_STAGES-1:0]          cand_valid;
    logic [NUM_FWD_STAGES*SLOT_RD_W-1:0] cand_rd;

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = valid_ID;
        id_slot.rd       = SLOT_RD_W'(rd_ID);
        id_slot.regwrite = RegWrite_ID;
        id_slot.is_load  = MemRead_ID;
    end

    // Load-use is only meaningful when EX is free to advance.
    assign load_use = !ex_busy && ex_slot.valid && ex_slot.is_load && ex_slot.regwrite
                      && (ex_slot.rd != '0) && valid_ID
                      && ((ex_slot.rd == SLOT_RD_W'(rs1_ID)) || (ex_slot.rd == SLOT_RD_W'(rs2_ID)));

    assign stall = !flush && (load_use || ex_busy);

    always_comb begin
        ex_nxt     = ex_slot;
        ex_rs1_nxt = ex_rs1;
        ex_rs2_nxt = ex_rs2;
        if (flush || (!ex_busy && load_use)) begin
            ex_nxt     = '0;
            ex_rs1_nxt = '0;
            ex_rs2_nxt = '0;
        end else if (!ex_busy) begin
            ex_nxt     = id_slot;
            ex_rs1_nxt = SLOT_RD_W'(rs1_ID);
            ex_rs2_nxt = SLOT_RD_W'(rs2_ID);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            fwd_slot <= '0;
        end else begin
            ex_slot     <= ex_nxt;
            ex_rs1      <= ex_rs1_nxt;
            ex_rs2      <= ex_rs2_nxt;
            fwd_slot[1] <= ex_busy ? '0 : ex_slot;
            for (int unsigned k = 2; k <= NUM_FWD_STAGES; k++) begin
                fwd_slot[k] <= fwd_slot[k-1];
            end
        end
    end

`ifdef HAZ_MULDIV_EN
    localparam int unsigned MD_CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    logic [MD_CW-1:0] md_cnt;
    logic             md_start;

    // A mul/div starts exactly when the ID fields are accepted into EX.
    assign md_start = !flush && !ex_busy && !load_use && valid_ID && MulDiv_ID;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            md_cnt <= '0;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end else if (md_start) begin
            md_cnt <= MD_CW'(MD_LAT - 1);
        end
    end

    assign ex_busy = (md_cnt != '0);
`else
    localparam int unsigned unused_md_lat = MD_LAT;
    logic unused_muldiv;

    assign unused_muldiv = MulDiv_ID;
    assign ex_busy       = 1'b0;
`endif

    always_comb begin
        cand_valid = '0;
        cand_rd    = '0;
        for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
            cand_valid[k-1] = fwd_slot[k].valid && fwd_slot[k].regwrite && (fwd_slot[k].rd != '0);
            cand_rd[(k-1)*SLOT_RD_W +: SLOT_RD_W] = fwd_slot[k].rd;
        end
    end

    fwd_select #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .RD_W           (SLOT_RD_W)
    ) u_fwd_a (
        .en         (ex_slot.valid),
        .src        (ex_rs1),
        .cand_valid (cand_valid),
        .cand_rd    (cand_rd),
        .sel        (ForwardA)
    );

    fwd_select #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .RD_W           (SLOT_RD_W)
    ) u_fwd_b (
        .en         (ex_slot.valid),
        .src        (ex_rs2),
        .cand_valid (cand_valid),
        .cand_rd    (cand_rd),
        .sel        (ForwardB)
    );

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the RV32I pipeline. It keeps its own shadow copy of the in-flight destination registers from ID through the last forwarding stage. From that copy it produces the EX-stage operand-bypass selects, a load-use stall and a multi-cycle (mul/div) EX hold. It sits beside the ID/EX pipeline registers, consumes decode fields from ID, and drives the stall/bubble controls of IF/ID and ID/EX together with the EX operand muxes.

## Interface
- `NUM_FWD_STAGES`, default 2: number of stages after EX that can forward; stage 1 = EX/MEM, stage N = last (WB side). Minimum 1.
- `REG_AW`, default 5: register-address width.
- `MD_LAT`, default 4: total EX-occupancy cycles of a mul/div op. Minimum 1.
- `FWD_W`, derived as $clog2(NUM_FWD_STAGES+1): forward-select width.
- `clk`  in  1  single clock, rising edge. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `valid_ID`  in  1  ID holds a real instruction.
- `rs1_ID`, `rs2_ID`  in  REG_AW  source registers of the ID instruction.
- `rd_ID`  in  REG_AW  destination register of the ID instruction.
- `RegWrite_ID`  in  1  the ID instruction writes rd.
- `MemRead_ID`  in  1  the ID instruction is a load.
- `MulDiv_ID`  in  1  the ID instruction is a multi-cycle op.
- `flush`  in  1  branch redirect; kills the ID and EX instructions.
- `ForwardA`, `ForwardB`  out  FWD_W  EX operand select.
- `stall`  out  1  hold PC and IF/ID, inject a bubble into ID/EX.
- `ex_busy`  out  1  a mul/div is occupying EX.

## Operation
- Shadow slots: EX plus S[1..N]. Each slot holds valid, rd, regwrite, is_load; EX additionally holds rs1 and rs2.
- Forward select encoding: 0 = register file; k = slot S[k].
- ForwardA is the smallest k with S[k].valid && S[k].regwrite && S[k].rd != 0 && S[k].rd == EX.rs1; if no k matches, it is 0. ForwardB is the same using EX.rs2. Nearest stage wins.
- Forwarding applies only while EX.valid; otherwise both selects are 0.
- Load-use: load_use = EX.valid && EX.is_load && EX.regwrite && EX.rd != 0 && valid_ID && (EX.rd == rs1_ID || EX.rd == rs2_ID). Compared only when ex_busy is 0.
- `stall` = !flush && (load_use || ex_busy).
- Mul/div counter `md_cnt`:
  - It loads MD_LAT-1 when a MulDiv instruction enters EX.
  - It decrements while nonzero.
  - `ex_busy` = (md_cnt != 0).
- Slot advance each cycle:
  - S[k] <= S[k-1] for k ≥ 2.
  - S[1] <= EX, or a bubble when ex_busy.
  - EX <= hold when ex_busy; a bubble when flush or load_use; otherwise the ID fields (valid = valid_ID).
- `flush` invalidates EX and clears md_cnt in the same edge. The instruction in S[1] is unaffected. Flush takes priority over ex_busy and load_use.
- A S[1] slot with is_load must never be selected for forwarding. The stall rule guarantees this; the verification engineer asserts it.

## Timing
- ForwardA, ForwardB, stall and ex_busy are combinational from registered slot state, plus the ID inputs for stall. They are valid in the same cycle.
- Load-use costs exactly 1 stall cycle. The consumer then forwards from S[2], or from the register file when N = 1.
- Mul/div: `stall` is high for MD_LAT-1 cycles, starting the cycle after the op enters EX. With MD_LAT = 1 there is no stall.
- Reset: all slots invalid, md_cnt = 0. In the cycle after reset: ForwardA = ForwardB = 0, stall = 0, ex_busy = 0. Reset mid-mul/div aborts it with no residual stall.
- Back-to-back mul/div: the second op enters EX when ex_busy drops and reloads the counter immediately.

## Configuration
- `HAZ_MULDIV_EN` defined: mul/div counter and EX-hold logic are present.
- `HAZ_MULDIV_EN` undefined: MulDiv_ID is ignored, ex_busy is tied to 0, and every instruction spends 1 cycle in EX.

## Structure
- Package `hazard_pkg` contains:
  - slot struct typedef (valid, rd, regwrite, is_load);
  - FWD_SEL_RF = 0 constant;
  - REG_AW default.
- Sub-module `fwd_select`: one instance per operand. It is a parametrised priority compare of one source register against the N slots and returns the FWD_W select.

## Test plan
- Defaults. `add x5` issued, then `sub` using x5 as rs1 in the next cycle → ForwardA = 1 in the sub's EX cycle; in the following cycle ForwardA = 0 for an unrelated op.
- `add x5`, then `or x5`, then `and` reading x5 on rs2 → ForwardB = 1 (nearest wins), never 2.
- `lw x7`, then `add` reading x7 → stall = 1 for exactly 1 cycle, EX bubble; then ForwardA = 2.
- HAZ_MULDIV_EN, MD_LAT = 4: `mul x3` followed by `add` reading x3 → ex_busy and stall high for 3 cycles; then ForwardA = 1. Same sequence with flush asserted on the 2nd busy cycle → ex_busy = 0 next cycle.
- Writes to x0 with RegWrite = 1 in every slot → ForwardA = ForwardB = 0 and stall = 0. The same check with `lw x0`.
- rst asserted during load_use, and separately during ex_busy → all outputs 0 the next cycle; no stale forwards after release.
